// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: register-file geometry, default producer
// latencies and the instruction class encoding seen by the ID stage.
package cpu_pipe_pkg;

  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int LAT_W    = 3;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_class_e;

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard slot: a countdown of cycles until a fixed-latency result
// becomes forwardable, plus a flag for an outstanding iterative divide.
// A fresh issue to the register wins over a flush clear, which wins over
// divide completion and the per-cycle countdown.
module scoreboard_entry #(
  parameter int LAT_W = cpu_pipe_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [LAT_W-1:0] load_val,
  input  logic             set_div,
  input  logic             clr,
  input  logic             clr_div,
  input  logic             dec,
  output logic             busy,
  output logic             div_pend
);

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             div_pend_q, div_pend_d;

  // Next-state selection for the countdown and the divide flag.
  always_comb begin
    // NOTE: defaulting every target to its held value first keeps this block free of inferred latches.
    cnt_d      = cnt_q;
    div_pend_d = div_pend_q;
    if (set) begin
      cnt_d      = load_val;
      div_pend_d = set_div;
    end else if (clr) begin
      cnt_d      = '0;
      div_pend_d = 1'b0;
    end else begin
      if (dec && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
      if (clr_div)              div_pend_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q      <= '0;
      div_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_pend_q <= div_pend_d;
    end
  end

  assign busy     = (cnt_q != '0) | div_pend_q;
  assign div_pend = div_pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard between ID and the ID/EX register.
// Tracks register writes whose results cannot be forwarded yet (loads,
// multi-cycle MUL, iterative DIV) and stalls IF/ID plus bubbles EX until
// every source of the ID instruction is forwardable.
// Optional build macro STALL_PERF_EN adds a saturating stall-cycle counter;
// without it perf_stall_cnt is tied to zero.
module hazard_scoreboard #(
  parameter int NUM_REGS = cpu_pipe_pkg::NUM_REGS,
  parameter int REG_W    = cpu_pipe_pkg::REG_W,
  parameter int LAT_W    = cpu_pipe_pkg::LAT_W,
  parameter int LOAD_LAT = cpu_pipe_pkg::LOAD_LAT,
  parameter int MUL_LAT  = cpu_pipe_pkg::MUL_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic                id_rs1_used,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_rs2_used,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_rd_wr,
  input  logic [1:0]          id_op_class,
  input  logic                ex_flush,
  input  logic                div_busy,
  input  logic                div_done,
  input  logic [REG_W-1:0]    div_rd,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic [31:0]         perf_stall_cnt
);

  import cpu_pipe_pkg::*;

  op_class_e           op_cls;
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] div_pend_vec;
  logic                hazard;
  logic                struct_haz;
  logic                stall;
  logic                issue;
  logic                wr_rd;
  logic                flush_clr;
  logic [LAT_W-1:0]    load_val;

  // The instruction issued last cycle; ex_flush squashes it in EX.
  logic                last_vld_q, last_vld_d;
  logic [REG_W-1:0]    last_rd_q, last_rd_d;
  op_class_e           last_cls_q, last_cls_d;

  // Hazard detection, stall/issue decision and the countdown value to load.
  always_comb begin
    op_cls     = op_class_e'(id_op_class);
    hazard     = id_valid & ((id_rs1_used & busy_vec[id_rs1]) |
                             (id_rs2_used & busy_vec[id_rs2]));
    struct_haz = id_valid & (op_cls == OP_DIV) & (div_busy | (|div_pend_vec));
    stall      = (hazard | struct_haz) & ~ex_flush;
    issue      = id_valid & ~stall & ~ex_flush;
    wr_rd      = issue & id_rd_wr;
    // An ALU producer already cleared its entry at issue, so only
    // long-latency producers leave anything to undo when squashed.
    flush_clr  = ex_flush & last_vld_q & (last_cls_q != OP_ALU);
    case (op_cls)
      OP_LOAD: load_val = LAT_W'(LOAD_LAT);
      OP_MUL:  load_val = LAT_W'(MUL_LAT);
      default: load_val = '0;
    endcase
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (wr_rd && (id_rd == REG_W'(r))),
      .load_val (load_val),
      .set_div  (op_cls == OP_DIV),
      .clr      (flush_clr && (last_rd_q == REG_W'(r))),
      .clr_div  (div_done && (div_rd == REG_W'(r))),
      .dec      (1'b1),
      .busy     (busy_vec[r]),
      .div_pend (div_pend_vec[r])
    );
  end

  // Remember which register-writing instruction entered EX this cycle.
  always_comb begin
    last_vld_d = wr_rd;
    last_rd_d  = id_rd;
    last_cls_d = op_cls;
  end

  // Last-issue registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_vld_q <= 1'b0;
      last_rd_q  <= '0;
      last_cls_q <= OP_ALU;
    end else begin
      last_vld_q <= last_vld_d;
      last_rd_q  <= last_rd_d;
      last_cls_q <= last_cls_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= 32'd0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

  assign stall_if   = stall;
  assign stall_id   = stall;
  assign bubble_ex  = stall;
  assign sb_pending = busy_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a timestamp-based reference model
// (each register records the cycle from which its value is forwardable).
module tb_hazard_scoreboard;

  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_rs1;
  logic        id_rs1_used;
  logic [3:0]  id_rs2;
  logic        id_rs2_used;
  logic [3:0]  id_rd;
  logic        id_rd_wr;
  logic [1:0]  id_op_class;
  logic        ex_flush;
  logic        div_busy;
  logic        div_done;
  logic [3:0]  div_rd;
  logic        stall_if;
  logic        stall_id;
  logic        bubble_ex;
  logic [15:0] sb_pending;
  logic [31:0] perf_stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int          cyc = 0;
  int          avail_at [16];
  bit          div_wait [16];
  bit          m_last_wr = 1'b0;
  logic [3:0]  m_last_rd = 4'd0;
  logic [31:0] m_perf = 32'd0;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs1_used    (id_rs1_used),
    .id_rs2         (id_rs2),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_rd_wr       (id_rd_wr),
    .id_op_class    (id_op_class),
    .ex_flush       (ex_flush),
    .div_busy       (div_busy),
    .div_done       (div_done),
    .div_rd         (div_rd),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .sb_pending     (sb_pending),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                     input logic w, input logic [1:0] cls);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_wr = w; id_op_class = cls;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
  endtask

  // Called just after a falling edge with inputs applied: compares outputs,
  // crosses one rising edge, advances the model, returns at the next falling edge.
  // want >= 0 additionally pins the stall value a scenario demands.
  task automatic step(input string tag, input int want);
    logic [15:0] exp_pend;
    bit any_div, haz, strc, exp_stall, issue;
    #1;
    any_div = 1'b0;
    for (int r = 0; r < 16; r++) begin
      exp_pend[r] = (cyc < avail_at[r]) || div_wait[r];
      any_div |= div_wait[r];
    end
    haz = id_valid && ((id_rs1_used && exp_pend[id_rs1]) || (id_rs2_used && exp_pend[id_rs2]));
    strc = id_valid && (id_op_class == 2'd3) && (div_busy || any_div);
    exp_stall = (haz || strc) && !ex_flush;
    check({tag, "_stall_if"},  32'(stall_if),  32'(exp_stall));
    check({tag, "_stall_id"},  32'(stall_id),  32'(exp_stall));
    check({tag, "_bubble_ex"}, 32'(bubble_ex), 32'(exp_stall));
    check({tag, "_pending"},   32'(sb_pending), 32'(exp_pend));
    check({tag, "_perf"},      perf_stall_cnt, m_perf);
    if (want >= 0) check({tag, "_directed"}, 32'(stall_if), 32'(want));
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) begin avail_at[r] = 0; div_wait[r] = 1'b0; end
      m_last_wr = 1'b0;
      m_perf    = 32'd0;
    end else begin
      issue = id_valid && !exp_stall && !ex_flush;
      if (ex_flush && m_last_wr) begin
        avail_at[m_last_rd] = 0;
        div_wait[m_last_rd] = 1'b0;
      end
      if (div_done) div_wait[div_rd] = 1'b0;
      if (issue && id_rd_wr) begin
        case (id_op_class)
          2'd1:    begin avail_at[id_rd] = cyc + 1 + LOAD_LAT; div_wait[id_rd] = 1'b0; end
          2'd2:    begin avail_at[id_rd] = cyc + 1 + MUL_LAT;  div_wait[id_rd] = 1'b0; end
          2'd3:    begin avail_at[id_rd] = 0;                  div_wait[id_rd] = 1'b1; end
          default: begin avail_at[id_rd] = 0;                  div_wait[id_rd] = 1'b0; end
        endcase
      end
      m_last_wr = issue && id_rd_wr;
      m_last_rd = id_rd;
`ifdef STALL_PERF_EN
      if (exp_stall && (m_perf != 32'hFFFF_FFFF)) m_perf = m_perf + 32'd1;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin avail_at[r] = 0; div_wait[r] = 1'b0; end
    rst_n = 1'b0; idle();
    ex_flush = 1'b0; div_busy = 1'b0; div_done = 1'b0; div_rd = 4'd0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    step("reset", 0);
    check("reset_pending", 32'(sb_pending), 32'd0);
    rst_n = 1'b1;

    // 1: LOAD r3, then ADD r5 = r3 + r1 stalls exactly one cycle.
    drv(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 2'd1); step("t1_load", 0);
    check("t1_pend3_set", 32'(sb_pending[3]), 32'd1);
    drv(1, 4'd3, 1, 4'd1, 1, 4'd5, 1, 2'd0); step("t1_use_wait", 1);
    check("t1_pend3_clr", 32'(sb_pending[3]), 32'd0);
    step("t1_use_go", 0);

    // 2: MUL r4 then use -> three stalls; an ALU write to r4 in between removes them.
    idle(); step("t2_idle", 0);
    drv(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 2'd2); step("t2_mul", 0);
    drv(1, 4'd1, 1, 4'd4, 1, 4'd6, 1, 2'd0);
    step("t2_wait1", 1); step("t2_wait2", 1); step("t2_wait3", 1); step("t2_go", 0);
    drv(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 2'd2); step("t2_mul_b", 0);
    drv(1, 4'd1, 1, 4'd0, 0, 4'd4, 1, 2'd0); step("t2_alu_waw", 0);
    drv(1, 4'd4, 1, 4'd0, 0, 4'd6, 1, 2'd0); step("t2_use_free", 0);

    // 3: DIV r7, dependent waits until the cycle after div_done for r7.
    drv(1, 4'd1, 1, 4'd2, 1, 4'd7, 1, 2'd3); step("t3_div", 0);
    div_busy = 1'b1;
    drv(1, 4'd7, 1, 4'd0, 0, 4'd8, 1, 2'd0);
    step("t3_wait1", 1); step("t3_wait2", 1);
    div_done = 1'b1; div_rd = 4'd7; step("t3_done", 1);
    div_done = 1'b0; div_busy = 1'b0; step("t3_go", 0);

    // 4: LOAD r2 squashed by ex_flush -> entry gone next cycle, no stall on use.
    drv(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 2'd1); step("t4_load", 0);
    drv(1, 4'd2, 1, 4'd0, 0, 4'd9, 1, 2'd0); ex_flush = 1'b1; step("t4_flush", 0);
    check("t4_pend2_clr", 32'(sb_pending[2]), 32'd0);
    ex_flush = 1'b0; step("t4_use", 0);

    // 5: second DIV while busy stalls structurally; an unused busy source does not stall.
    drv(1, 4'd0, 0, 4'd0, 0, 4'd8, 1, 2'd3); step("t5_div", 0);
    div_busy = 1'b1;
    drv(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 2'd3); step("t5_div2", 1);
    check("t5_pend_same", 32'(sb_pending), 32'h0100);
    drv(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 2'd1); step("t5_load3", 0);
    drv(1, 4'd3, 0, 4'd0, 0, 4'd10, 1, 2'd0); step("t5_rs1_unused", 0);
    idle(); div_done = 1'b1; div_rd = 4'd8; step("t5_done", 0);
    div_done = 1'b0; div_busy = 1'b0; step("t5_idle", 0);

    // 6: reset with cnt[6] == 2 clears every output.
    drv(1, 4'd0, 0, 4'd0, 0, 4'd6, 1, 2'd2); step("t6_mul", 0);
    idle(); step("t6_count", 0);
    check("t6_pend6", 32'(sb_pending[6]), 32'd1);
    rst_n = 1'b0; step("t6_reset", 0);
    check("t6_pend_zero", 32'(sb_pending), 32'd0);
    check("t6_stall_zero", 32'(stall_if), 32'd0);
    check("t6_perf_zero", perf_stall_cnt, 32'd0);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drv($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      ex_flush = ($urandom_range(0, 7) == 0);
      div_busy = ($urandom_range(0, 2) == 0);
      div_done = ($urandom_range(0, 5) == 0);
      div_rd   = 4'($urandom_range(0, 15));
      step("rand", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
